// File: rtl/hazard_stall_ctrl_pkg.sv
// hazard_stall_ctrl_pkg: shared CPU constants and the source-hazard rule.
package hazard_stall_ctrl_pkg;
    localparam int REG_W = 5;
    localparam logic [3:0] MULT_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES = 4'd10;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // A source stalls when a pending producer delivers later than D needs it.
    function automatic logic src_stall(
        input logic [REG_W-1:0] src,
        input logic [1:0] tuse,
        input logic [REG_W-1:0] e_dst,
        input logic [1:0] e_tnew,
        input logic [REG_W-1:0] m_dst,
        input logic [1:0] m_tnew
    );
        return (src != '0) && (tuse != TUSE_NONE) &&
               ((src == e_dst && tuse < e_tnew) || (src == m_dst && tuse < m_tnew));
    endfunction
endpackage

// File: rtl/hazard_stall_ctrl_md_busy_ctr.sv
// md_busy_ctr: multiply/divide unit busy countdown.
module md_busy_ctr
    import hazard_stall_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);
    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = reset ? 4'd0
              : (start && !busy) ? (is_div ? DIV_CYCLES : MULT_CYCLES)
              : (cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    end

    always_ff @(posedge clk) cnt_q <= cnt_d;

    assign busy = (cnt_q != 4'd0);
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: D-stage stall decision, pipeline enables and stall counter.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] D_rs,
    input  logic [REG_W-1:0] D_rt,
    input  logic [1:0]       D_rs_tuse,
    input  logic [1:0]       D_rt_tuse,
    input  logic [REG_W-1:0] E_dst,
    input  logic [REG_W-1:0] M_dst,
    input  logic [1:0]       E_tnew,
    input  logic [1:0]       M_tnew,
    input  logic             D_is_md,
    input  logic             E_md_start,
    input  logic             E_md_div,
    output logic             pc_en,
    output logic             fd_en,
    output logic             de_refresh,
    output logic             em_en,
    output logic             mw_en,
    output logic             md_busy,
    output logic [15:0]      stall_cnt
);
    logic stall_rs, stall_rt, stall_md, stall;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    md_busy_ctr u_md (
        .clk    (clk),
        .reset  (reset),
        .start  (E_md_start),
        .is_div (E_md_div),
        .busy   (md_busy)
    );

    always_comb begin
        stall_rs = src_stall(D_rs, D_rs_tuse, E_dst, E_tnew, M_dst, M_tnew);
        stall_rt = src_stall(D_rt, D_rt_tuse, E_dst, E_tnew, M_dst, M_tnew);
        stall_md = D_is_md && (E_md_start || md_busy);
        stall = stall_rs || stall_rt || stall_md;
        stall_cnt_d = reset ? 16'd0
                    : (stall && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    end

    always_ff @(posedge clk) stall_cnt_q <= stall_cnt_d;

    assign pc_en = !stall;
    assign fd_en = !stall;
    assign de_refresh = stall;
    assign em_en = 1'b1;
    assign mw_en = 1'b1;
    assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: randomized + directed scoreboard bench for hazard_stall_ctrl.
module tb_hazard_stall_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [4:0] D_rs = '0, D_rt = '0, E_dst = '0, M_dst = '0;
    logic [1:0] D_rs_tuse = 2'd3, D_rt_tuse = 2'd3, E_tnew = '0, M_tnew = '0;
    logic D_is_md = 1'b0, E_md_start = 1'b0, E_md_div = 1'b0;
    logic pc_en, fd_en, de_refresh, em_en, mw_en, md_busy;
    logic [15:0] stall_cnt;

    typedef struct {
        logic [4:0] rs, rt, ed, md;
        logic [1:0] rs_tu, rt_tu, et, mt;
        logic is_md, st, dv, rst;
    } in_t;

    typedef struct {
        bit stall, busy;
        int cnt;
    } exp_t;

    exp_t sb[$];
    int checks = 0, failures = 0;
    int cyc = 0, busy_until = -1, total = 0;
    bit valid = 0, pstall = 0;
    in_t pv;

    hazard_stall_ctrl dut (
        .clk(clk), .reset(reset), .D_rs(D_rs), .D_rt(D_rt),
        .D_rs_tuse(D_rs_tuse), .D_rt_tuse(D_rt_tuse), .E_dst(E_dst), .M_dst(M_dst),
        .E_tnew(E_tnew), .M_tnew(M_tnew), .D_is_md(D_is_md), .E_md_start(E_md_start),
        .E_md_div(E_md_div), .pc_en(pc_en), .fd_en(fd_en), .de_refresh(de_refresh),
        .em_en(em_en), .mw_en(mw_en), .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic in_t idle();
        in_t v;
        v.rs = 0; v.rt = 0; v.ed = 0; v.md = 0;
        v.rs_tu = 3; v.rt_tu = 3; v.et = 0; v.mt = 0;
        v.is_md = 0; v.st = 0; v.dv = 0; v.rst = 0;
        return v;
    endfunction

    // Result of a producer is late when it arrives after the consumer needs it.
    function automatic bit late(input int src, input int tuse, input int dst, input int tnew);
        return src != 0 && tuse != 3 && src == dst && tnew > tuse;
    endfunction

    task automatic step(input in_t v);
        exp_t e;
        @(posedge clk);
        #1;
        if (pv.rst) begin
            busy_until = cyc;
            total = 0;
            valid = 1;
        end else begin
            if (pv.st && cyc > busy_until) busy_until = cyc + (pv.dv ? 10 : 5);
            if (pstall) total++;
        end
        cyc++;
        D_rs = v.rs; D_rt = v.rt; D_rs_tuse = v.rs_tu; D_rt_tuse = v.rt_tu;
        E_dst = v.ed; M_dst = v.md; E_tnew = v.et; M_tnew = v.mt;
        D_is_md = v.is_md; E_md_start = v.st; E_md_div = v.dv; reset = v.rst;
        e.busy = cyc <= busy_until;
        e.stall = late(v.rs, v.rs_tu, v.ed, v.et) || late(v.rs, v.rs_tu, v.md, v.mt) ||
                  late(v.rt, v.rt_tu, v.ed, v.et) || late(v.rt, v.rt_tu, v.md, v.mt) ||
                  (v.is_md && (v.st || e.busy));
        e.cnt = total > 65535 ? 65535 : total;
        pstall = e.stall;
        pv = v;
        if (valid) sb.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pc_en", int'(pc_en), int'(!e.stall));
                chk("fd_en", int'(fd_en), int'(!e.stall));
                chk("de_refresh", int'(de_refresh), int'(e.stall));
                chk("em_en", int'(em_en), 1);
                chk("mw_en", int'(mw_en), 1);
                chk("md_busy", int'(md_busy), int'(e.busy));
                chk("stall_cnt", int'(stall_cnt), e.cnt);
            end
        end
    end

    initial begin : stim
        in_t v;
        pv = idle();
        pv.rst = 1;
        v = idle(); v.rst = 1;
        repeat (2) step(v);
        v = idle(); v.ed = 8; v.et = 2; v.rs = 8; v.rs_tu = 1;
        step(v);
        v = idle(); v.md = 8; v.mt = 1; v.rt = 8; v.rt_tu = 1;
        step(v);
        v = idle(); v.ed = 0; v.et = 2; v.md = 0; v.mt = 3; v.rs = 0; v.rs_tu = 0; v.rt = 0; v.rt_tu = 0;
        step(v);
        v = idle(); v.st = 1; step(v);
        for (int i = 1; i <= 7; i++) begin
            v = idle(); v.is_md = (i == 3); step(v);
        end
        v = idle(); v.st = 1; v.dv = 1; step(v);
        for (int i = 1; i <= 12; i++) begin
            v = idle(); v.st = (i == 2); v.dv = (i == 2); step(v);
        end
        v = idle(); v.st = 1; v.dv = 1; step(v);
        for (int i = 1; i <= 8; i++) begin
            v = idle(); v.rst = (i == 4); v.is_md = (i == 5); step(v);
        end
        for (int i = 0; i < 3000; i++) begin
            v.rs = 5'($urandom_range(0, 3)); v.rt = 5'($urandom_range(0, 3));
            v.ed = 5'($urandom_range(0, 3)); v.md = 5'($urandom_range(0, 3));
            v.rs_tu = 2'($urandom); v.rt_tu = 2'($urandom);
            v.et = 2'($urandom); v.mt = 2'($urandom);
            v.is_md = $urandom_range(0, 3) == 0; v.st = $urandom_range(0, 7) == 0;
            v.dv = 1'($urandom); v.rst = $urandom_range(0, 99) == 0;
            step(v);
        end
        v = idle(); v.rst = 1; step(v);
        v = idle(); v.ed = 8; v.et = 2; v.rs = 8; v.rs_tu = 1;
        repeat (70010) step(v);
        v = idle();
        repeat (3) step(v);
        @(negedge clk);
        @(posedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 SHALL have `clk`, input, 1 bit: clock; all state is updated on its rising edge.
REQ-002 SHALL have `reset`, input, 1 bit: reset, synchronous, active-high; clock `clk`.
REQ-003 SHALL have `D_rs`, `D_rt`, input, 5 bits each: source registers of the instruction in D.
REQ-004 SHALL have `D_rs_tuse`, `D_rt_tuse`, input, 2 bits each: cycles until the source is needed; 0..2 valid, 3 = TUSE_NONE (source unused).
REQ-005 SHALL have `E_dst`, `M_dst`, input, 5 bits each: destination register in E/M; 0 = no write.
REQ-006 SHALL have `E_tnew`, `M_tnew`, input, 2 bits each: stage-adjusted cycles until the result is available.
REQ-007 SHALL have `D_is_md`, input, 1 bit: D holds mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
REQ-008 SHALL have `E_md_start`, input, 1 bit: E holds a valid mult/div issuing this cycle.
REQ-009 SHALL have `E_md_div`, input, 1 bit: 1 = div-type, 0 = mult-type; qualified by `E_md_start`.
REQ-010 SHALL have `pc_en`, `fd_en`, output, 1 bit each: enables for the PC and the F/D register.
REQ-011 SHALL have `de_refresh`, output, 1 bit: bubble insert (clear) for the D/E register.
REQ-012 SHALL have `em_en`, `mw_en`, output, 1 bit each: E/M and M/W register enables.
REQ-013 SHALL have `md_busy`, output, 1 bit: MDU result pending.
REQ-014 SHALL have `stall_cnt`, output, 16 bits: performance counter of stalled cycles.

Function
REQ-015 SHALL assert `stall_rs` when `D_rs` != 0, `D_rs_tuse` != 3 and (`D_rs` == `E_dst` and `D_rs_tuse` < `E_tnew`, or `D_rs` == `M_dst` and `D_rs_tuse` < `M_tnew`); `stall_rt` SHALL be formed the same way from `D_rt`.
REQ-016 SHALL assert `stall_md` = `D_is_md` & (`E_md_start` | `md_busy`).
REQ-017 SHALL assert `stall` = `stall_rs` | `stall_rt` | `stall_md`; `stall` SHALL be purely combinational, with zero-cycle latency.
REQ-018 SHALL drive, on stall: `pc_en`=0, `fd_en`=0, `de_refresh`=1; otherwise `pc_en`=1, `fd_en`=1, `de_refresh`=0.
REQ-019 SHALL tie `em_en` and `mw_en` to 1; downstream stages never freeze.
REQ-020 SHALL maintain a 4-bit MDU counter `md_cnt` with `md_busy` = (`md_cnt` != 0).
REQ-021 SHALL load `md_cnt`, on an edge where `E_md_start`=1 and `md_busy`=0, with DIV_CYCLES (10) if `E_md_div`=1, else MULT_CYCLES (5).
REQ-022 SHALL decrement `md_cnt` by 1 on every other edge while `md_cnt` != 0, and hold it at 0 otherwise.
REQ-023 SHALL ignore `E_md_start` while `md_busy`=1 (no reload, no error).
REQ-024 SHALL assert `md_busy` for exactly 5 cycles after a mult start cycle and 10 cycles after a div start cycle.
REQ-025 SHALL increment `stall_cnt` by 1 on each edge where `stall`=1, saturating at 0xFFFF with no wrap.
REQ-026 SHALL give register 0 no stall even when `E_dst`/`M_dst` = 0 match.

Reset
REQ-027 SHALL clear `md_cnt` to 0 and `stall_cnt` to 0 on an edge with `reset`=1, overriding any start or stall in the same cycle.
REQ-028 SHALL drive outputs after reset as `md_busy`=0 and `stall_cnt`=0, with the combinational outputs following the current inputs.
REQ-029 SHALL abort an in-flight MDU operation and drop `md_busy` in the next cycle when `reset` is asserted mid-operation.

Structure
REQ-030 SHALL place MULT_CYCLES=5, DIV_CYCLES=10, TUSE_NONE=3 and the register-index width (5) in the shared CPU constants package.
REQ-031 SHALL implement `md_cnt` in one sub-module, `md_busy_ctr` (ports: clk, reset, start, is_div, busy).

Verification
REQ-032 SHALL cover a load-use case: E_dst=8, E_tnew=2, D_rs=8, D_rs_tuse=1 -> `pc_en`=0, `fd_en`=0, `de_refresh`=1 for that cycle, and `stall_cnt` +1.
REQ-033 SHALL cover a no-stall case: M_dst=8, M_tnew=1, D_rt=8, D_rt_tuse=1 -> `pc_en`=1, `de_refresh`=0.
REQ-034 SHALL cover a mult start: `E_md_start`=1, `E_md_div`=0 at cycle N -> `md_busy`=1 in N+1..N+5 and 0 at N+6; `D_is_md`=1 during N+3 -> stall.
REQ-035 SHALL cover a div start, plus a second start at N+2 -> `md_busy`=1 in N+1..N+10 only (second start ignored).
REQ-036 SHALL cover reset at N+4 of a div -> `md_busy`=0 at N+5, and `stall_cnt`=0.
REQ-037 SHALL cover 70000 consecutive stall cycles -> `stall_cnt`=0xFFFF, held.
